// File: rtl/grid_canvas_ctrl_if.sv
// Canvas memory port: synchronous write plus a read address whose data returns one cycle later.
interface grid_canvas_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, output wr_addr, output wr_data, output rd_addr, input rd_data);
  modport slave  (input wr_en, input wr_addr, input wr_data, input rd_addr, output rd_data);
endinterface

// File: rtl/grid_canvas_ctrl.sv
// Drawing-grid controller: wipes the canvas, moves a keyboard-driven cursor, inks or erases
// cells, and streams the canvas to a VGA adapter with the cursor cell highlighted.
module grid_canvas_ctrl #(
  parameter int unsigned GRID_W      = 28,
  parameter int unsigned GRID_H      = 28,
  parameter int unsigned PIXEL_SCALE = 4,
  parameter int unsigned DATA_W      = 32,
  parameter logic signed [DATA_W-1:0] INK = 1,
  parameter int unsigned MOVE_DELAY  = 2000000,
  localparam int unsigned CELLS  = GRID_W * GRID_H,
  localparam int unsigned ADDR_W = $clog2(CELLS),
  localparam int unsigned XW     = $clog2(GRID_W),
  localparam int unsigned YW     = $clog2(GRID_H),
  localparam int unsigned VX     = $clog2(GRID_W * PIXEL_SCALE),
  localparam int unsigned VY     = $clog2(GRID_H * PIXEL_SCALE),
  localparam int unsigned CW     = $clog2(MOVE_DELAY + 1),
  localparam int unsigned PS_SH  = $clog2(PIXEL_SCALE)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      on,
  input  logic                      key_valid,
  input  logic [7:0]                key_code,
  input  logic                      draw,
  input  logic                      erase,
  input  logic                      clear,
  grid_canvas_ctrl_if.master        mem,
  output logic [VX-1:0]             vga_x,
  output logic [VY-1:0]             vga_y,
  output logic [2:0]                vga_colour,
  output logic                      vga_plot,
  output logic [XW-1:0]             cursor_x,
  output logic [YW-1:0]             cursor_y,
  output logic                      busy
);

  typedef enum logic [0:0] {StClear, StMove} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]     cur_x_q, cur_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d;
  logic [CW-1:0]     cool_q, cool_d;
  logic              brk_q, brk_d;
  logic [VX-1:0]     sx_q, sx_d;
  logic [VY-1:0]     sy_q, sy_d;
  logic [VX-1:0]     vx_q;
  logic [VY-1:0]     vy_q;
  logic [XW-1:0]     cell_x_q, scan_cx;
  logic [YW-1:0]     cell_y_q, scan_cy;
  logic              plot_q;
  logic              moved;
  logic [ADDR_W-1:0] cur_addr;

  assign scan_cx     = XW'(sx_q >> PS_SH);
  assign scan_cy     = YW'(sy_q >> PS_SH);
  assign mem.rd_addr = ADDR_W'(scan_cy) * ADDR_W'(GRID_W) + ADDR_W'(scan_cx);
  assign cur_addr    = ADDR_W'(cur_y_q) * ADDR_W'(GRID_W) + ADDR_W'(cur_x_q);
  assign cursor_x    = cur_x_q;
  assign cursor_y    = cur_y_q;
  assign vga_x       = vx_q;
  assign vga_y       = vy_q;
  assign vga_plot    = plot_q;

  // FSM state register; on=0 freezes it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StClear;
    end else if (on) begin
      state_q <= state_d;
    end
  end

  // FSM next state: sweep ends after the last cell, clear restarts it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (cnt_q == ADDR_W'(CELLS - 1)) state_d = StMove;
      StMove:  if (clear) state_d = StClear;
      default: state_d = StClear;
    endcase
  end

  // FSM outputs: canvas write port and busy flag.
  always_comb begin
    mem.wr_en   = 1'b0;
    mem.wr_addr = '0;
    mem.wr_data = '0;
    busy        = (state_q == StClear);
    if (on && !reset) begin
      unique case (state_q)
        StClear: begin
          mem.wr_en   = 1'b1;
          mem.wr_addr = cnt_q;
        end
        StMove: begin
          // Erase wins over draw; clear suppresses both.
          if (!clear && (erase || draw)) begin
            mem.wr_en   = 1'b1;
            mem.wr_addr = cur_addr;
            mem.wr_data = erase ? '0 : INK;
          end
        end
        default: ;
      endcase
    end
  end

  // Key decoding, cursor stepping, cooldown and sweep counter next state.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    brk_d   = brk_q;
    cool_d  = cool_q;
    cnt_d   = cnt_q;
    moved   = 1'b0;
    if (cool_q != '0) cool_d = cool_q - 1'b1;
    // E0 (extended prefix) leaves the break flag untouched.
    if (key_valid && key_code != 8'hE0) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (key_code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (state_q == StMove && !clear && cool_q == '0) begin
        case (key_code)
          8'h6B: if (cur_x_q != '0) begin
            cur_x_d = cur_x_q - 1'b1;
            moved   = 1'b1;
          end
          8'h74: if (cur_x_q != XW'(GRID_W - 1)) begin
            cur_x_d = cur_x_q + 1'b1;
            moved   = 1'b1;
          end
          8'h75: if (cur_y_q != '0) begin
            cur_y_d = cur_y_q - 1'b1;
            moved   = 1'b1;
          end
          8'h72: if (cur_y_q != YW'(GRID_H - 1)) begin
            cur_y_d = cur_y_q + 1'b1;
            moved   = 1'b1;
          end
          default: ;
        endcase
      end
    end
    // Only a step that actually moved starts a cooldown.
    if (moved) cool_d = CW'(MOVE_DELAY);
    if (state_q == StClear) begin
      cnt_d = (cnt_q == ADDR_W'(CELLS - 1)) ? '0 : cnt_q + 1'b1;
    end else if (clear) begin
      cnt_d = '0;
    end
  end

  // Free-running raster scanner next state, sx fastest.
  always_comb begin
    sx_d = sx_q + 1'b1;
    sy_d = sy_q;
    if (sx_q == VX'(GRID_W * PIXEL_SCALE - 1)) begin
      sx_d = '0;
      sy_d = (sy_q == VY'(GRID_H * PIXEL_SCALE - 1)) ? '0 : sy_q + 1'b1;
    end
  end

  // Datapath state; all of it holds while on=0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q   <= '0;
      cur_x_q <= XW'(GRID_W / 2);
      cur_y_q <= YW'(GRID_H / 2);
      cool_q  <= '0;
      brk_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else if (on) begin
      cnt_q   <= cnt_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cool_q  <= cool_d;
      brk_q   <= brk_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  // Delay pixel position one cycle so it lines up with rd_data.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vx_q     <= '0;
      vy_q     <= '0;
      cell_x_q <= '0;
      cell_y_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      vx_q     <= sx_q;
      vy_q     <= sy_q;
      cell_x_q <= scan_cx;
      cell_y_q <= scan_cy;
      plot_q   <= on;
    end
  end

  // Pixel colour: cursor red, inked white, empty blue.
  always_comb begin
    vga_colour = 3'b001;
    if (plot_q) begin
      if (cell_x_q == cur_x_q && cell_y_q == cur_y_q) begin
        vga_colour = 3'b100;
      end else if (mem.rd_data != '0) begin
        vga_colour = 3'b111;
      end
    end
  end

endmodule

// File: tb/tb_grid_canvas_ctrl.sv
// Directed bench for grid_canvas_ctrl with a write scoreboard and a behavioural canvas memory.
module tb_grid_canvas_ctrl;
  localparam int unsigned GW = 28;
  localparam int unsigned GH = 28;
  localparam int unsigned PS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MD = 4;
  localparam int unsigned CELLS = GW * GH;
  localparam int unsigned AW = $clog2(CELLS);
  localparam int unsigned XW = $clog2(GW);
  localparam int unsigned YW = $clog2(GH);
  localparam int unsigned VXW = $clog2(GW * PS);
  localparam int unsigned VYW = $clog2(GH * PS);

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic           reset, on, key_valid, draw, erase, clear;
  logic [7:0]     key_code;
  logic [VXW-1:0] vga_x;
  logic [VYW-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy;
  logic [XW-1:0]  cursor_x;
  logic [YW-1:0]  cursor_y;

  grid_canvas_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  grid_canvas_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .PIXEL_SCALE(PS), .DATA_W(DW), .INK(1), .MOVE_DELAY(MD)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .on(on), .key_valid(key_valid), .key_code(key_code),
    .draw(draw), .erase(erase), .clear(clear), .mem(mem_if),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  // Read-before-write canvas, preloaded with non-zero junk so the wipe is visible.
  logic [DW-1:0] canvas [CELLS] = '{default: 32'hDEAD_BEEF};
  always @(posedge CLOCK_50) begin
    mem_if.rd_data <= canvas[mem_if.rd_addr];
    if (mem_if.wr_en) canvas[mem_if.wr_addr] <= mem_if.wr_data;
  end

  int compared = 0;
  int mismatched = 0;
  logic [AW+DW-1:0] exp_q [$];
  int exp_x, exp_y;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard any write at mid-cycle, then return just after the edge.
  task automatic cyc();
    logic [AW+DW-1:0] e;
    @(negedge CLOCK_50);
    if (mem_if.wr_en !== 1'b0) begin
      check("sb_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_write", 64'({mem_if.wr_en, mem_if.wr_addr, mem_if.wr_data}), 64'({1'b1, e}));
      end
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cyc();
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, 64'(cursor_x), 64'(exp_x));
    check({tag, "_y"}, 64'(cursor_y), 64'(exp_y));
  endtask

  // Saturating model step, then wait out exactly the cooldown.
  task automatic move(input logic [7:0] c);
    case (c)
      8'h6B: if (exp_x > 0) exp_x--;
      8'h74: if (exp_x < int'(GW) - 1) exp_x++;
      8'h75: if (exp_y > 0) exp_y--;
      8'h72: if (exp_y < int'(GH) - 1) exp_y++;
      default: ;
    endcase
    key(c);
    check_cursor("move");
    repeat (MD) cyc();
  endtask

  task automatic wait_cell(input int cx, input int cy, input logic [2:0] col, input string tag);
    int n = 0;
    while (!(vga_plot === 1'b1 && int'(vga_x) / int'(PS) == cx && int'(vga_y) / int'(PS) == cy)
           && n < 13000) begin
      cyc();
      n++;
    end
    check({tag, "_found"}, 64'(n < 13000), 64'd1);
    check(tag, 64'(vga_colour), 64'(col));
  endtask

  task automatic push_sweep();
    for (int i = 0; i < int'(CELLS); i++) exp_q.push_back({AW'(i), DW'(0)});
  endtask

  initial begin
    reset = 1'b1; on = 1'b1; key_valid = 1'b0; key_code = 8'h00;
    draw = 1'b0; erase = 1'b0; clear = 1'b0;
    exp_x = 14; exp_y = 14;
    cyc(); cyc();
    check("rst_busy", 64'(busy), 64'd1);
    check_cursor("rst_cursor");
    check("rst_wr_en", 64'(mem_if.wr_en), 64'd0);
    check("rst_wr_addr", 64'(mem_if.wr_addr), 64'd0);
    check("rst_wr_data", 64'(mem_if.wr_data), 64'd0);
    check("rst_plot", 64'(vga_plot), 64'd0);
    check("rst_colour", 64'(vga_colour), 64'd1);

    // Power-up wipe; keys and draw must be ignored while it runs.
    reset = 1'b0;
    push_sweep();
    check("sweep_busy", 64'(busy), 64'd1);
    for (int i = 0; i < int'(CELLS); i++) begin
      key_valid = (i == 5);
      key_code  = 8'h74;
      draw      = (i < 10);
      cyc();
    end
    key_valid = 1'b0; draw = 1'b0;
    check("sweep_done_busy", 64'(busy), 64'd0);
    check("sweep_drained", 64'(exp_q.size()), 64'd0);
    check_cursor("sweep_cursor");
    check("move_idle_wr_en", 64'(mem_if.wr_en), 64'd0);
    check("plot_on", 64'(vga_plot), 64'd1);

    // Erase beats draw, then draw inks cell 406.
    draw = 1'b1; erase = 1'b1;
    exp_q.push_back({AW'(406), DW'(0)});
    cyc();
    erase = 1'b0;
    exp_q.push_back({AW'(406), DW'(1)});
    cyc();
    draw = 1'b0;
    check("draw_drained", 64'(exp_q.size()), 64'd0);

    // Cooldown: E0,74 moves; repeat two cycles later is dropped; after cooldown it moves.
    key(8'hE0); key(8'h74);
    exp_x = 15;
    check_cursor("cool_first");
    cyc();
    key(8'hE0); key(8'h74);
    check_cursor("cool_dropped");
    key(8'hE0); key(8'h74);
    exp_x = 16;
    check_cursor("cool_after");
    repeat (MD) cyc();

    // Raster along row 14: inked, empty, cursor.
    wait_cell(14, 14, 3'b111, "pix_ink");
    wait_cell(15, 14, 3'b001, "pix_empty");
    wait_cell(16, 14, 3'b100, "pix_cursor");

    // Break code swallows the next byte only.
    key(8'hF0); key(8'h74);
    check_cursor("break_swallow");
    move(8'h74);

    // Walk to (0,5); blocked left leaves no cooldown, so right is taken at once.
    while (exp_x > 0) move(8'h6B);
    while (exp_y > 5) move(8'h75);
    key(8'h6B);
    check_cursor("blocked_left");
    key(8'h74);
    exp_x = 1;
    check_cursor("after_blocked");
    repeat (MD) cyc();
    repeat (6) move(8'h75);
    repeat (27) move(8'h74);
    repeat (28) move(8'h72);
    check_cursor("corner");

    // Clear beats draw; sweep pauses while on=0.
    draw = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_busy", 64'(busy), 64'd1);
    push_sweep();
    for (int j = 0; j < int'(CELLS) + 3; j++) begin
      on   = !(j >= 300 && j < 303);
      draw = (j < 50);
      if (!on) begin
        #1;
        check("off_wr_en", 64'(mem_if.wr_en), 64'd0);
        check("off_busy", 64'(busy), 64'd1);
        if (j > 300) check("off_plot", 64'(vga_plot), 64'd0);
      end
      cyc();
    end
    on = 1'b1; draw = 1'b0;
    check("clear_done_busy", 64'(busy), 64'd0);
    check("clear_drained", 64'(exp_q.size()), 64'd0);
    check_cursor("clear_cursor");
    check("resume_plot", 64'(vga_plot), 64'd1);
    cyc();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/grid_canvas_ctrl.md
GRID_CANVAS_CTRL -- requirements
Module: grid_canvas_ctrl

Interface
REQ-001 Parameter GRID_W, default 28, canvas width in cells.
REQ-002 Parameter GRID_H, default 28, canvas height in cells.
REQ-003 Parameter PIXEL_SCALE, default 4, VGA pixels per cell edge; power of two, 1..8.
REQ-004 Parameter DATA_W, default 32, cell word width.
REQ-005 Parameter INK, default 1, value written by a draw (DATA_W bits, signed).
REQ-006 Parameter MOVE_DELAY, default 2000000, cursor cooldown in cycles; minimum 1.
REQ-007 Derived widths: ADDR_W = clog2(GRID_W*GRID_H), XW = clog2(GRID_W), YW = clog2(GRID_H), VX = clog2(GRID_W*PIXEL_SCALE), VY = clog2(GRID_H*PIXEL_SCALE).
REQ-008 CLOCK_50  in  1  clock; all logic rising-edge.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 on  in  1  global enable; 0 freezes all state.
REQ-011 key_valid  in  1  one-cycle strobe: key_code holds a new PS/2 byte.
REQ-012 key_code  in  8  raw PS/2 set-2 byte.
REQ-013 draw  in  1  level: ink the cursor cell.
REQ-014 erase  in  1  level: zero the cursor cell.
REQ-015 clear  in  1  level: request a full-canvas wipe; sampled in MOVE.
REQ-016 wr_en / wr_addr / wr_data  out  1 / ADDR_W / DATA_W  canvas write port.
REQ-017 rd_addr  out  ADDR_W  canvas read address; rd_data  in  DATA_W  returned exactly 1 cycle later.
REQ-018 vga_x / vga_y / vga_colour / vga_plot  out  VX / VY / 3 / 1  pixel stream to VGA adapter.
REQ-019 cursor_x / cursor_y  out  XW / YW  cursor cell position.
REQ-020 busy  out  1  high while in CLEAR.

Function
REQ-021 Control FSM states CLEAR, MOVE; reset enters CLEAR with sweep counter 0.
REQ-022 CLEAR: each enabled cycle wr_en=1, wr_addr=counter, wr_data=0, counter+1; after address GRID_W*GRID_H-1 go to MOVE next cycle; keys, draw, erase ignored.
REQ-023 MOVE: if clear=1 go to CLEAR, counter 0, cursor unchanged; clear has priority over all other MOVE actions that cycle.
REQ-024 Key decoder: byte F0 arms break flag; next byte discarded and flag cleared; byte E0 ignored (neither arms nor clears break).
REQ-025 Make codes 6B/74/75/72 = left/right/up/down, accepted in MOVE only when cooldown counter = 0; other codes ignored.
REQ-026 Accepted move steps cursor by one cell, saturating at 0 and GRID_W-1 / GRID_H-1; a step that moves loads cooldown with MOVE_DELAY; a saturated (blocked) step does not load it.
REQ-027 Cooldown decrements by 1 each enabled cycle while nonzero, in any state; keys arriving during cooldown are dropped, not queued.
REQ-028 MOVE writes: erase=1 → wr_en=1, wr_data=0; else draw=1 → wr_en=1, wr_data=INK; wr_addr = cursor_y*GRID_W + cursor_x using the pre-move cursor of that cycle; wr_en=0 otherwise.
REQ-029 Refresh scanner: free-running raster sx 0..GRID_W*PIXEL_SCALE-1, sy 0..GRID_H*PIXEL_SCALE-1, sx fastest, wraps to (0,0); runs in both FSM states.
REQ-030 rd_addr = (sy/PIXEL_SCALE)*GRID_W + sx/PIXEL_SCALE, combinational from scanner.
REQ-031 vga_x, vga_y, vga_plot delayed 1 cycle to align with rd_data; vga_plot=1 whenever on=1 and reset not asserted.
REQ-032 vga_colour: 3'b100 if the aligned cell equals the cursor cell, else 3'b111 if rd_data != 0, else 3'b001.
REQ-033 on=0: scanner, FSM, cursor, cooldown, key decoder hold; wr_en=0; vga_plot=0; key_valid ignored.
REQ-034 Same-cycle write and read to one address returns old data on rd_data (read-before-write memory assumed by display only).

Reset
REQ-035 Reset values: cursor (GRID_W/2, GRID_H/2), cooldown 0, break flag 0, scanner (0,0), wr_en=0, wr_addr=0, wr_data=0, vga_plot=0, vga_colour=3'b001, busy=1 (CLEAR).
REQ-036 Reset asserted mid-CLEAR or mid-cooldown restarts the sweep from address 0 and zeroes cooldown.

Verification
REQ-037 Reset, on=1 → 784 consecutive writes of 0 to addresses 0..783, busy falls the cycle after address 783, cursor (14,14).
REQ-038 MOVE_DELAY=4: bytes E0,74 → cursor_x 15; E0,74 again 2 cycles later → dropped; after 4 cycles E0,74 → cursor_x 16.
REQ-039 Byte sequence F0,74 → no movement; following 74 → cursor_x +1.
REQ-040 Cursor at (0,5), left arrow → cursor stays (0,5), cooldown stays 0; immediate right arrow → (1,5).
REQ-041 Cursor (14,14), draw=1 and erase=1 same cycle → wr_en=1, wr_addr=406, wr_data=0; draw only → wr_data=1; raster over cell (14,14) after cursor moves shows 3'b111.
REQ-042 clear=1 during draw in MOVE → no ink write that cycle, next 784 cycles write 0, on=0 mid-sweep holds counter and wr_en=0 until on=1.
